// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus fabric: bus field widths and the
// request/response FSM state encoding.
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WSTRB_W = 4;

  // IDLE : no transaction outstanding
  // WAIT : request forwarded to a slave, waiting for its ready pulse
  // ERR  : unmapped address, error response goes out this cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer
// Counts the cycles a transaction has spent waiting on its slave and flags
// the cycle in which the wait limit is reached.
//
// Ports:
//   clk     : clock, counting on the rising edge
//   rst     : asynchronous active-high reset, count returns to 0
//   clear   : restart the count at 0 (a new transaction was accepted)
//   enable  : advance the count by one this cycle
//   expired : high while the count equals TIMEOUT-1, i.e. the current
//             cycle is the last one the slave is allowed to answer in
// ---------------------------------------------------------------------------
module bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // Clear has priority so a back-to-back accept always starts from zero,
  // even in a cycle where the previous wait would otherwise have counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/bus_fabric.sv
// ---------------------------------------------------------------------------
// bus_fabric
// Single-master, NSLAVE-slave request/response fabric. The top SEL_W address
// bits pick the slave; unmapped addresses and slaves that stay silent for
// TIMEOUT cycles both produce an error response. A saturating counter keeps
// track of how many error responses have been returned.
//
// Ports:
//   clk_i, rst_i          : clock and asynchronous active-high reset
//   m_enable_i            : master request valid
//   m_wstrb_i             : byte write strobes, all zero for a read
//   m_addr_i, m_wvalue_i  : master address and write data
//   m_rvalue_o            : read data, zero unless a good read completes
//   m_ready_o, m_err_o    : one-cycle response pulse and its error flag
//   s_enable_o            : one-hot request pulse towards the slaves
//   s_wstrb_o, s_addr_o,
//   s_wvalue_o            : master fields forwarded to every slave
//   s_rvalue_i            : packed slave read data, slave i at [32*i +: 32]
//   s_ready_i             : per-slave completion pulse
//   err_count_o           : saturating count of error responses
// ---------------------------------------------------------------------------
module bus_fabric
  import bus_pkg::*;
#(
  parameter int NSLAVE  = 4,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_enable_i,
  input  logic [WSTRB_W-1:0]       m_wstrb_i,
  input  logic [ADDR_W-1:0]        m_addr_i,
  input  logic [DATA_W-1:0]        m_wvalue_i,
  output logic [DATA_W-1:0]        m_rvalue_o,
  output logic                     m_ready_o,
  output logic                     m_err_o,
  output logic [NSLAVE-1:0]        s_enable_o,
  output logic [WSTRB_W-1:0]       s_wstrb_o,
  output logic [ADDR_W-1:0]        s_addr_o,
  output logic [DATA_W-1:0]        s_wvalue_o,
  input  logic [NSLAVE*DATA_W-1:0] s_rvalue_i,
  input  logic [NSLAVE-1:0]        s_ready_i,
  output logic [7:0]               err_count_o
);

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   sel_q;
  logic               wr_q;
  logic [7:0]         err_count;
  logic               mapped;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;
  logic               accept;
  logic               timer_enable;
  logic               timer_expired;

  // Slave-side request fields are plain wires; only s_enable_o is decoded.
  assign s_wstrb_o  = m_wstrb_i;
  assign s_addr_o   = m_addr_i;
  assign s_wvalue_o = m_wvalue_i;

  assign idx    = m_addr_i[ADDR_W-1 -: SEL_W];
  assign mapped = (32'(idx) < 32'(NSLAVE));

  // Pick out the ready and read data of the slave that owns the outstanding
  // transaction. Written as a compare loop so sel_q never indexes past the
  // last real slave when NSLAVE is smaller than 2**SEL_W.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready_i[i];
        sel_rdata = s_rvalue_i[DATA_W*i +: DATA_W];
      end
    end
  end

  // A new request is taken when nothing is outstanding, or when the
  // outstanding one completes in this very cycle (back-to-back throughput).
  // Reset gates it so no slave sees a request while rst_i is high.
  assign accept = !rst_i && m_enable_i &&
                  ((state == IDLE) || ((state == WAIT) && sel_ready));

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (accept),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State register plus the per-transaction bookkeeping: which slave owns
  // the transaction, whether it is a write (so its response carries no
  // data), and the saturating error counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state <= state_next;
      if (accept && mapped) begin
        sel_q <= idx;
        wr_q  <= (m_wstrb_i != '0);
      end
      if (m_err_o && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign err_count_o = err_count;

  // Response generation and next state. A slave ready beats the timeout in
  // the same cycle; the timeout cycle itself never accepts a new request
  // because accept requires the selected slave to be ready. The accept
  // decision is applied last so it overrides the return to IDLE.
  always_comb begin
    state_next   = state;
    m_ready_o    = 1'b0;
    m_err_o      = 1'b0;
    m_rvalue_o   = '0;
    s_enable_o   = '0;
    timer_enable = 1'b0;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      WAIT: begin
        if (sel_ready) begin
          m_ready_o  = 1'b1;
          m_rvalue_o = wr_q ? '0 : sel_rdata;
          state_next = IDLE;
        end else if (timer_expired) begin
          m_ready_o  = 1'b1;
          m_err_o    = 1'b1;
          state_next = IDLE;
        end else begin
          timer_enable = 1'b1;
        end
      end
      ERR: begin
        m_ready_o  = 1'b1;
        m_err_o    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      if (mapped) begin
        state_next = WAIT;
        for (int i = 0; i < NSLAVE; i++) begin
          s_enable_o[i] = (idx == SEL_W'(i));
        end
      end else begin
        state_next = ERR;
      end
    end
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter NSLAVE, default 4, number of slave ports (1..2**SEL_W).
REQ-002 Parameter SEL_W, default 3, number of top address bits used as the slave index.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before an error response (1..65535).
REQ-004 Port clk_i, in, 1, single clock; all state updates on posedge.
REQ-005 Port rst_i, in, 1, reset; asynchronous and active-high.
REQ-006 Port m_enable_i, in, 1, master request valid.
REQ-007 Port m_wstrb_i, in, 4, byte write strobes; 0 means read.
REQ-008 Port m_addr_i, in, 32, master address.
REQ-009 Port m_wvalue_i, in, 32, master write data.
REQ-010 Port m_rvalue_o, out, 32, read data, valid only when m_ready_o=1.
REQ-011 Port m_ready_o, out, 1, one-cycle response pulse.
REQ-012 Port m_err_o, out, 1, error qualifier, valid with m_ready_o.
REQ-013 Port s_enable_o, out, NSLAVE, one-hot per-slave request pulse.
REQ-014 Ports s_wstrb_o / s_addr_o / s_wvalue_o, out, 4/32/32, combinational copies of the master fields, shared by all slaves.
REQ-015 Port s_rvalue_i, in, NSLAVE*32, packed slave read data; slave i occupies bits [32*i+31 : 32*i].
REQ-016 Port s_ready_i, in, NSLAVE, per-slave completion pulse.
REQ-017 Port err_count_o, out, 8, saturating count of error responses.

Function
REQ-018 Decode: idx = m_addr_i[31 -: SEL_W]; the address is mapped iff idx < NSLAVE.
REQ-019 FSM states: IDLE, WAIT, ERR.
REQ-020 Accept condition: m_enable_i=1, and either state=IDLE or (state=WAIT and the selected slave's s_ready_i=1).
REQ-021 On accept with a mapped address: s_enable_o[idx]=1 in that same cycle (combinational); sel_q<=idx; timer<=0; next state WAIT.
REQ-022 On accept with an unmapped address: no s_enable_o bit is set; next state ERR.
REQ-023 ERR: m_ready_o=1, m_err_o=1 and m_rvalue_o=0 for exactly one cycle, then IDLE; m_enable_i is ignored in this cycle.
REQ-024 WAIT with s_ready_i[sel_q]=1: m_ready_o=1, m_err_o=0, m_rvalue_o=s_rvalue_i[sel_q]; next state IDLE unless a new accept occurs in the same cycle.
REQ-025 WAIT without ready: timer increments by 1 per cycle.
REQ-026 Timeout: when timer=TIMEOUT-1 and no ready arrives, m_ready_o=1, m_err_o=1, m_rvalue_o=0 in that cycle; next state IDLE.
REQ-027 A new request is not accepted in the timeout cycle.
REQ-028 Ready and timeout in the same cycle: ready wins; m_err_o=0.
REQ-029 A late s_ready_i arriving after a timeout or while IDLE is ignored.
REQ-030 In WAIT, s_ready_i from non-selected slaves is ignored.
REQ-031 m_enable_i in WAIT without ready is ignored; the master holds its fields until m_ready_o.
REQ-032 Throughput: a slave answering one cycle after enable gives one response per cycle for back-to-back requests.
REQ-033 Read and write follow the same handshake; for writes, m_rvalue_o is a don't-care but is driven 0.
REQ-034 m_rvalue_o=0 whenever m_ready_o=0.
REQ-035 err_count_o increments by 1 on every m_err_o pulse and saturates at 255.

Reset
REQ-036 While rst_i=1: state=IDLE, sel_q=0, timer=0, err_count_o=0; m_ready_o=0, m_err_o=0, s_enable_o=0.
REQ-037 Reset asserted mid-transaction abandons the transaction; no response is produced after deassertion.
REQ-038 The first accept can occur in the first clock edge after rst_i falls.

Structure
REQ-039 Package bus_pkg holds the FSM state enum, ADDR_W=32, DATA_W=32 and WSTRB_W=4.
REQ-040 Sub-module bus_timer contains the WAIT timeout counter (clear, enable, expired inputs/outputs), parametrised by TIMEOUT.

Verification
REQ-041 Read, addr 0x2000_0010, slave1 ready next cycle with 0xDEADBEEF -> s_enable_o=0010 for 1 cycle; next cycle m_ready_o=1, m_rvalue_o=0xDEADBEEF, m_err_o=0.
REQ-042 Back-to-back reads to slave0 and slave2, each slave ready after 1 cycle -> responses on consecutive cycles; s_enable_o sequence 0001, 0100.
REQ-043 Addr 0xA000_0000 with NSLAVE=4 -> no s_enable_o; next cycle m_ready_o=1, m_err_o=1, m_rvalue_o=0; err_count_o=1.
REQ-044 TIMEOUT=4, slave3 never ready -> m_ready_o=1 with m_err_o=1 in the 4th WAIT cycle; a ready on the 5th cycle is ignored.
REQ-045 Slave2 ready after 3 cycles, rst_i pulsed in the 2nd WAIT cycle -> no m_ready_o; state IDLE; err_count_o=0.
REQ-046 300 unmapped requests -> err_count_o saturates at 255.
